// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues BRAM reads from an internal PC and queues {pc, instr} for decode.
// The issue credit counts the in-flight read, so a returning word always finds a free slot.
module instr_fetch_unit #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_V = (PW+2)'(FIFO_DEPTH);
  localparam logic [PW:0]   FULL_V  = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [31:0]   issue_pc;
  logic [31:0]   redirect_base;
  logic          inflight;
  logic          issue;
  logic          pop;
  logic          push;
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;
  logic [PW+1:0] committed;
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  assign count         = wr_ptr - rd_ptr;
  assign if_valid      = (count != '0);
  assign pop           = if_valid & if_ready;
  assign push          = inflight & ~redirect_valid;
  assign committed     = {1'b0, count} + (PW+2)'(inflight) - (PW+2)'(pop);
  assign redirect_base = redirect_pc & ~32'h3;

  // A redirect bypasses the PC register so its first read goes out in the same cycle.
  assign issue_pc  = redirect_valid ? redirect_base : pc;
  assign issue     = fetch_en & (redirect_valid | (committed < DEPTH_V));
  assign imem_addr = issue_pc[ADDR_W+1:2];

  assign imem_we    = 1'b0;
  assign imem_wdata = 32'h0;

  assign if_instr = if_valid ? fifo_instr[rd_ptr[PW-1:0]] : 32'h0;
  assign if_pc    = if_valid ? fifo_pc[rd_ptr[PW-1:0]]    : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= issue_pc;
      end
      if (redirect_valid) begin
        pc     <= redirect_base + (fetch_en ? 32'd4 : 32'd0);
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (issue) begin
          pc <= pc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + (PW+1)'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + (PW+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr[PW-1:0]]    <= req_pc;
      fifo_instr[wr_ptr[PW-1:0]] <= imem_rdata;
    end
  end

`ifndef SYNTHESIS
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL_V));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed latency/stall/redirect/wrap/reset scenarios plus a
// randomized run scored against an in-order PC stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int errors = 0;
  int checks = 0;

  logic [31:0] bram [1024];

  instr_fetch_unit #(.ADDR_W(10), .RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= bram[imem_addr];

  function automatic logic [31:0] word_of(input logic [31:0] p);
    return 32'h1000_0000 + {22'd0, p[11:2]};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    next_cycle();
    rst = 1'b1; fetch_en = 1'b1; redirect_valid = 1'b0; if_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic warm(input int n);
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset;
    next_cycle();
    rst = 1'b1; fetch_en = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    checks += 6;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", if_valid); end
    if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", if_pc); end
    if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h expected 0", if_instr); end
    if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", imem_we); end
    if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h expected 0", imem_wdata); end
    if (imem_addr !== RESET_PC[11:2]) begin errors++; $display("FAIL reset_addr got %0d expected %0d", imem_addr, RESET_PC[11:2]); end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset();
    fetch_en = 1'b1; if_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      checks++;
      if (imem_addr !== 10'(c)) begin errors++; $display("FAIL stream_addr c=%0d got %0d expected %0d", c, imem_addr, c); end
      if (c < 2) begin
        checks++;
        if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c=%0d got %b expected 0", c, if_valid); end
      end else begin
        e = 32'(4 * (c - 2));
        checks += 3;
        if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c=%0d got %b expected 1", c, if_valid); end
        if (if_pc !== e) begin errors++; $display("FAIL stream_pc c=%0d got %h expected %h", c, if_pc, e); end
        if (if_instr !== word_of(e)) begin errors++; $display("FAIL stream_instr c=%0d got %h expected %h", c, if_instr, word_of(e)); end
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] e;
    warm(6);
    if_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) next_cycle();
      @(negedge clk);
      checks += 3;
      if (if_valid !== 1'b1 || if_pc !== 32'h10) begin errors++; $display("FAIL stall_head s=%0d got v=%b pc=%h expected v=1 pc=10", s, if_valid, if_pc); end
      if (if_instr !== word_of(32'h10)) begin errors++; $display("FAIL stall_instr s=%0d got %h expected %h", s, if_instr, word_of(32'h10)); end
      if (imem_addr !== 10'd6) begin errors++; $display("FAIL stall_addr s=%0d got %0d expected 6", s, imem_addr); end
    end
    next_cycle();
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      e = 32'h10 + 32'(4 * k);
      checks += 2;
      if (if_valid !== 1'b1 || if_pc !== e) begin errors++; $display("FAIL stall_resume k=%0d got v=%b pc=%h expected v=1 pc=%h", k, if_valid, if_pc, e); end
      if (if_instr !== word_of(e)) begin errors++; $display("FAIL stall_resume_instr k=%0d got %h expected %h", k, if_instr, word_of(e)); end
    end
  endtask

  task automatic test_fetch_disable;
    logic [31:0] exp_pc [4];
    logic        exp_v  [4];
    exp_pc = '{32'h10, 32'h14, 32'h0, 32'h0};
    exp_v  = '{1'b1, 1'b1, 1'b0, 1'b0};
    warm(6);
    fetch_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      checks += 2;
      if (imem_addr !== 10'd6) begin errors++; $display("FAIL fe_addr c=%0d got %0d expected 6", c, imem_addr); end
      if (if_valid !== exp_v[c] || if_pc !== exp_pc[c]) begin errors++; $display("FAIL fe_drain c=%0d got v=%b pc=%h expected v=%b pc=%h", c, if_valid, if_pc, exp_v[c], exp_pc[c]); end
    end
    next_cycle();
    fetch_en = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL fe_restart_gap got %b expected 0", if_valid); end
    if (imem_addr !== 10'd7) begin errors++; $display("FAIL fe_restart_addr got %0d expected 7", imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h18) begin errors++; $display("FAIL fe_restart_pc got v=%b pc=%h expected v=1 pc=18", if_valid, if_pc); end
  endtask

  task automatic test_redirect;
    warm(6);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd64) begin errors++; $display("FAIL redir_bypass_addr got %0d expected 64", imem_addr); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got v=%b pc=%h expected v=0", if_valid, if_pc); end
    if (imem_addr !== 10'd65) begin errors++; $display("FAIL redir_next_addr got %0d expected 65", imem_addr); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      checks += 2;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL redir_pc k=%0d got v=%b pc=%h expected %h", k, if_valid, if_pc, 32'h100 + 32'(4 * k)); end
      if (if_instr !== word_of(32'h100 + 32'(4 * k))) begin errors++; $display("FAIL redir_instr k=%0d got %h expected %h", k, if_instr, word_of(32'h100 + 32'(4 * k))); end
    end
    next_cycle();
    if_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h108) begin errors++; $display("FAIL redir_stall_head got v=%b pc=%h expected v=1 pc=108", if_valid, if_pc); end
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    next_cycle();
    redirect_valid = 1'b0; if_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_full_flush got v=%b pc=%h expected v=0", if_valid, if_pc); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin errors++; $display("FAIL redir_full_pc got v=%b pc=%h expected v=1 pc=200", if_valid, if_pc); end
  endtask

  task automatic test_redirect_pop;
    warm(6);
    redirect_valid = 1'b1; redirect_pc = 32'h103; if_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b1) begin errors++; $display("FAIL rpop_precond got %b expected 1", if_valid); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL rpop_discard got v=%b pc=%h expected v=0", if_valid, if_pc); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL rpop_pc k=%0d got v=%b pc=%h expected %h", k, if_valid, if_pc, 32'h100 + 32'(4 * k)); end
    end
  endtask

  task automatic test_wrap;
    warm(4);
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd1023) begin errors++; $display("FAIL wrap_addr0 got %0d expected 1023", imem_addr); end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 10'd0) begin errors++; $display("FAIL wrap_addr1 got %0d expected 0", imem_addr); end
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFC) begin errors++; $display("FAIL wrap_pc0 got v=%b pc=%h expected FFC", if_valid, if_pc); end
    if (if_instr !== 32'h1000_03FF) begin errors++; $display("FAIL wrap_instr0 got %h expected 100003ff", if_instr); end
    next_cycle();
    @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b1 || if_pc !== 32'h1000) begin errors++; $display("FAIL wrap_pc1 got v=%b pc=%h expected 1000", if_valid, if_pc); end
    if (if_instr !== 32'h1000_0000) begin errors++; $display("FAIL wrap_instr1 got %h expected 10000000", if_instr); end
  endtask

  task automatic test_mid_reset;
    warm(8);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks += 2;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b expected 0", if_valid); end
    if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL mrst_outputs got pc=%h instr=%h expected 0", if_pc, if_instr); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_gap got %b expected 0", if_valid); end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== RESET_PC + 32'(4 * k)) begin errors++; $display("FAIL mrst_restart k=%0d got v=%b pc=%h expected %h", k, if_valid, if_pc, RESET_PC + 32'(4 * k)); end
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    int          pops;
    do_reset();
    exp_pc = RESET_PC;
    prev_stall = 1'b0; prev_pc = 32'h0; prev_instr = 32'h0;
    pops = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) next_cycle();
      rst            = ($urandom_range(0, 199) == 0);
      fetch_en       = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 32) == 0);
      if ($urandom_range(0, 1) == 0) redirect_pc = $urandom();
      else redirect_pc = 32'hFF0 + 32'($urandom_range(0, 15));
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
          errors++;
          $display("FAIL rnd_stall_stable c=%0d got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", c, if_valid, if_pc, if_instr, prev_pc, prev_instr);
        end
      end
      if (!rst && redirect_valid) begin
        checks++;
        if (imem_addr !== redirect_pc[11:2]) begin errors++; $display("FAIL rnd_bypass c=%0d got %0d expected %0d", c, imem_addr, redirect_pc[11:2]); end
      end
      if (rst) begin
        exp_pc = RESET_PC;
      end else if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (if_valid === 1'b1 && if_ready) begin
        checks++;
        if (if_pc !== exp_pc || if_instr !== word_of(exp_pc)) begin
          errors++;
          $display("FAIL rnd_order c=%0d got pc=%h instr=%h expected pc=%h instr=%h", c, if_pc, if_instr, exp_pc, word_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      prev_stall = !rst && !redirect_valid && (if_valid === 1'b1) && !if_ready;
      prev_pc    = if_pc;
      prev_instr = if_instr;
    end
    checks++;
    if (pops < 300) begin errors++; $display("FAIL rnd_progress got %0d pops expected at least 300", pops); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = 32'h1000_0000 + 32'(i);
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_fetch_disable();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
